booth4_mul: RTL and testbench
=============================

// Module: booth4_mul
// PURPOSE
//  Sequential radix-4 Booth multiplier. It is the multiply-side companion of the SRT4 divider
//  and uses the same valid/ready operand/result handshake. It retires one Booth digit
//  (2 multiplier bits) per cycle. Operands are unsigned or two's complement, selected per
//  operation. It sits beside the divider in the arithmetic unit and shares its issue logic.
// PARAMETERS
//  WID  8  operand width; must be even and >= 4. Digit count N = WID/2 + 1.
// PORTS
//  clk           input   1        single clock, rising edge
//  rst           input   1        synchronous active-low reset (rst==0 resets on clk edge)
//  multiplicand  input   WID      operand M; sampled only on accept
//  multiplier    input   WID      operand B; sampled only on accept
//  sgn           input   1        1: operands two's complement; 0: unsigned; sampled on accept
//  valid         input   1        operand request
//  busy          output  1        high in WORK and DONE; valid is ignored while busy
//  ready         output  1        one-cycle pulse: product is valid
//  product       output  2*WID    full-width result; holds until the next DONE or reset
// BEHAVIOUR
//  Reset (rst==0 at an edge): state=IDLE, busy=0, ready=0, product=0, and all internal
//   registers cleared. This applies in any state. A reset during WORK aborts the operation
//   with no ready pulse.
//  States (3-bit encoding): IDLE=000, WORK=001, DONE=010; other codes go to IDLE.
//   IDLE: accept when valid=1.
//     If M==0 or B==0: go to DONE with product 0 (shortcut, no WORK cycles).
//     Otherwise: go to WORK and load cnt=N-1.
//   WORK: one digit per cycle. When cnt==0 at the edge, go to DONE; otherwise cnt-=1.
//   DONE: ready=1 (decoded from state), product registered this cycle, then go to IDLE
//     unconditionally. valid in DONE is dropped; the earliest next accept is the cycle after.
//  Latency: valid in IDLE at cycle t gives WORK for t+1..t+N and ready at t+N+1.
//   For WID=8 that is ready at t+6. The zero shortcut gives ready at t+1.
//  Operand extension on accept:
//   - B is extended to WID+2 bits: sign-extended if sgn, else zero-extended.
//     A 0 is appended below the LSB, giving a WID+3-bit shift register.
//   - M is extended to WID+2 bits the same way. +-2M then fits without overflow.
//  Digit recode of triplet {b[2i+1],b[2i],b[2i-1]}:
//   000,111 -> 0;  001,010 -> +1M;  011 -> +2M;  100 -> -2M;  101,110 -> -1M.
//   Negation is ~x+1, with the +1 injected as the adder carry-in.
//  Datapath per WORK cycle (shift-add, signed):
//   - acc_hi (WID+2 bits) += digit*M.
//   - Then {acc_hi, B-shift register} is arithmetic-shifted right by 2.
//   - After N digits, product = accumulator bits [2*WID-1:0].
//   - Unsigned 255*255 needs all N digits and must not wrap.
//  The product register is written only in DONE; ready is never asserted outside DONE.
// STRUCTURE
//  Shared package (alongside the divider constants): state encodings IDLE/WORK/DONE, and
//   the digit encoding {neg, mag[1:0]} with mag 00=0, 01=1M, 10=2M. The divider's quotient
//   digit uses the same encoding.
//  Sub-module booth4_sel: combinational. Input: 3-bit triplet. Outputs: neg, mag[1:0].
//   It is the Booth counterpart of the divider's quotient-select block.
//  Top: FSM, cnt, operand registers, (WID+2)-bit adder with carry-in, product register.
// TESTING
//  1. WID=8, sgn=0, 13*11, valid at t
//     -> ready only at t+6, product=16'h008F; busy high t+1..t+6.
//  2. sgn=0, 255*255 -> product=16'hFE01 (checks the extra digit and no wrap).
//  3. sgn=1, -128*-128 -> 16'h4000; sgn=1, -128*127 -> 16'hC080.
//  4. 0*200 -> ready at t+1, product=0. Then 1*200 via normal path -> 16'h00C8 at its t+6.
//  5. valid held high continuously, alternating operands: each op is accepted only in IDLE.
//     Results are spaced by N+2 cycles and product holds between pulses.
//  6. rst=0 during the 3rd WORK cycle -> next cycle state IDLE, product=0, no ready pulse.
//     A following 7*9 op -> 16'h003F.
//  Plus: random constrained sweep of both sgn modes against a reference model.

Source files
------------

// File: rtl/booth4_pkg.sv
// Shared arithmetic-unit definitions: FSM state codes and the signed-digit
// encoding used by both the Booth multiplier and the SRT4 divider.
package booth4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_WORK = 3'b001,
    ST_DONE = 3'b010
  } state_t;

  // Digit magnitude; the sign travels separately as 'neg'.
  typedef enum logic [1:0] {
    MAG_ZERO = 2'b00,
    MAG_ONE  = 2'b01,
    MAG_TWO  = 2'b10
  } mag_t;

  typedef struct packed {
    logic neg;
    mag_t mag;
  } digit_t;

endpackage

// File: rtl/booth4_sel.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet to a signed digit
// in {-2,-1,0,+1,+2}, expressed as sign plus magnitude.
module booth4_sel
  import booth4_pkg::*;
(
  input  logic [2:0] triplet,
  output logic       neg,
  output logic [1:0] mag
);

  digit_t digit;

  always_comb begin
    digit = '{neg: 1'b0, mag: MAG_ZERO};
    case (triplet)
      3'b001, 3'b010: digit = '{neg: 1'b0, mag: MAG_ONE};
      3'b011:         digit = '{neg: 1'b0, mag: MAG_TWO};
      3'b100:         digit = '{neg: 1'b1, mag: MAG_TWO};
      3'b101, 3'b110: digit = '{neg: 1'b1, mag: MAG_ONE};
      default:        digit = '{neg: 1'b0, mag: MAG_ZERO};
    endcase
  end

  assign neg = digit.neg;
  assign mag = digit.mag;

endmodule

// File: rtl/booth4_mul.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, with a
// valid/ready handshake shared with the SRT4 divider.
module booth4_mul
  import booth4_pkg::*;
#(
  parameter int WID = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WID-1:0]     multiplicand,
  input  logic [WID-1:0]     multiplier,
  input  logic               sgn,
  input  logic               valid,
  output logic               busy,
  output logic               ready,
  output logic [2*WID-1:0]   product
);

  localparam int N  = WID / 2 + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t            state;
  state_t            next_state;
  logic [CW-1:0]     cnt;
  logic [WID+1:0]    m_reg;
  logic [WID+1:0]    acc_hi;
  logic [WID+2:0]    breg;

  logic              neg;
  logic [1:0]        mag;
  logic [WID+1:0]    addend;
  logic [WID+1:0]    addend_sel;
  logic [WID+1:0]    sum;
  logic [WID+1:0]    acc_next;
  logic [WID+2:0]    breg_next;
  logic [2*WID-1:0]  prod_next;
  logic [WID+1:0]    m_ext;
  logic [WID+1:0]    b_ext;
  logic              zero_op;

  assign m_ext   = sgn ? {{2{multiplicand[WID-1]}}, multiplicand} : {2'b00, multiplicand};
  assign b_ext   = sgn ? {{2{multiplier[WID-1]}}, multiplier} : {2'b00, multiplier};
  assign zero_op = (multiplicand == '0) || (multiplier == '0);

  booth4_sel u_sel (
    .triplet (breg[2:0]),
    .neg     (neg),
    .mag     (mag)
  );

  // Shift-add step; negation is the inverted addend plus a carry-in of 1.
  always_comb begin
    addend = '0;
    case (mag)
      MAG_ONE: addend = m_reg;
      MAG_TWO: addend = {m_reg[WID:0], 1'b0};
      default: addend = '0;
    endcase
    addend_sel = neg ? ~addend : addend;
    sum        = acc_hi + addend_sel + {{(WID+1){1'b0}}, neg};
    acc_next   = {{2{sum[WID+1]}}, sum[WID+1:2]};
    breg_next  = {sum[1:0], breg[WID+2:2]};
    prod_next  = {acc_next[WID-3:0], breg_next[WID+2:1]};
  end

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (valid) next_state = zero_op ? ST_DONE : ST_WORK;
        else       next_state = ST_IDLE;
      end
      ST_WORK: next_state = (cnt == '0) ? ST_DONE : ST_WORK;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // The product register loads on the edge entering DONE so it is already
  // valid while ready is high, then holds until the next result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      m_reg   <= '0;
      acc_hi  <= '0;
      breg    <= '0;
      product <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            acc_hi <= '0;
            cnt    <= CW'(N - 1);
            if (zero_op) begin
              m_reg   <= '0;
              breg    <= '0;
              product <= '0;
            end else begin
              m_reg <= m_ext;
              breg  <= {b_ext, 1'b0};
            end
          end
        end
        ST_WORK: begin
          acc_hi <= acc_next;
          breg   <= breg_next;
          if (cnt == '0) product <= prod_next;
          else           cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == ST_WORK) || (state == ST_DONE);
  assign ready = (state == ST_DONE);

endmodule

// File: tb/tb_booth4_mul.sv
// Self-checking bench for booth4_mul: directed handshake/latency cases plus a
// randomized sweep compared against plain integer multiplication.
module tb_booth4_mul;

  localparam int WID = 8;
  localparam int N   = WID / 2 + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [WID-1:0]     multiplicand;
  logic [WID-1:0]     multiplier;
  logic               sgn;
  logic               valid;
  logic               busy;
  logic               ready;
  logic [2*WID-1:0]   product;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth4_mul #(.WID(WID)) dut (
    .clk          (clk),
    .rst          (rst),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .sgn          (sgn),
    .valid        (valid),
    .busy         (busy),
    .ready        (ready),
    .product      (product)
  );

  // Reference: exact integer product of the operands as interpreted by sgn.
  function automatic logic [2*WID-1:0] refProduct(input logic [WID-1:0] a,
                                                   input logic [WID-1:0] b,
                                                   input logic s);
    longint ra, rb, p;
    ra = s ? longint'($signed(a)) : longint'(a);
    rb = s ? longint'($signed(b)) : longint'(b);
    p  = ra * rb;
    return p[2*WID-1:0];
  endfunction

  function automatic int refLatency(input logic [WID-1:0] a, input logic [WID-1:0] b);
    return (a == '0 || b == '0) ? 1 : N + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issues one operation and counts cycles (sampled on negedges) until ready.
  task automatic applyStimulus(input logic [WID-1:0] a, input logic [WID-1:0] b,
                               input logic s, output int lat, output bit busyOk);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    sgn          = s;
    valid        = 1'b1;
    lat          = 0;
    busyOk       = 1'b1;
    forever begin
      @(negedge clk);
      valid = 1'b0;
      lat++;
      if (!busy) busyOk = 1'b0;
      if (ready) break;
      if (lat >= 30) begin
        lat = -1;
        break;
      end
    end
  endtask

  int               lat;
  bit               busyOk;
  logic [WID-1:0]   ra, rb;
  logic             rs;

  logic [WID-1:0]   opA [4] = '{8'd13, 8'd200, 8'd77, 8'd255};
  logic [WID-1:0]   opB [4] = '{8'd11, 8'd3, 8'd150, 8'd255};
  logic             opS [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst          = 1'b0;
    valid        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    sgn          = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    rst = 1'b1;

    applyStimulus(8'd13, 8'd11, 1'b0, lat, busyOk);
    checkOutput("t1_latency", 32'(lat), 32'(N + 1));
    checkOutput("t1_busy", 32'(busyOk), 32'd1);
    checkOutput("t1_product", 32'(product), 32'h008F);
    @(negedge clk);
    checkOutput("t1_idle_after", 32'({busy, ready}), 32'd0);

    applyStimulus(8'd255, 8'd255, 1'b0, lat, busyOk);
    checkOutput("t2_product", 32'(product), 32'hFE01);

    applyStimulus(8'h80, 8'h80, 1'b1, lat, busyOk);
    checkOutput("t3_neg_neg", 32'(product), 32'h4000);
    applyStimulus(8'h80, 8'h7F, 1'b1, lat, busyOk);
    checkOutput("t3_neg_pos", 32'(product), 32'hC080);

    applyStimulus(8'd0, 8'd200, 1'b0, lat, busyOk);
    checkOutput("t4_zero_latency", 32'(lat), 32'd1);
    checkOutput("t4_zero_product", 32'(product), 32'd0);
    applyStimulus(8'd1, 8'd200, 1'b0, lat, busyOk);
    checkOutput("t4_one_latency", 32'(lat), 32'(N + 1));
    checkOutput("t4_one_product", 32'(product), 32'h00C8);

    // Valid held high: each accept happens only in the IDLE cycle after DONE.
    begin
      int gap;
      bit holdOk;
      logic [2*WID-1:0] lastProd;
      holdOk   = 1'b1;
      lastProd = product;
      @(negedge clk);
      multiplicand = opA[0];
      multiplier   = opB[0];
      sgn          = opS[0];
      valid        = 1'b1;
      for (int k = 0; k < 4; k++) begin
        gap = 0;
        forever begin
          @(negedge clk);
          gap++;
          if (ready) break;
          if (product !== lastProd) holdOk = 1'b0;
          if (gap >= 30) break;
        end
        checkOutput($sformatf("t5_ready_%0d", k), 32'(ready), 32'd1);
        checkOutput($sformatf("t5_product_%0d", k), 32'(product),
                    32'(refProduct(opA[k], opB[k], opS[k])));
        if (k > 0) checkOutput($sformatf("t5_spacing_%0d", k), 32'(gap), 32'(N + 2));
        lastProd = product;
        if (k < 3) begin
          multiplicand = opA[k+1];
          multiplier   = opB[k+1];
          sgn          = opS[k+1];
        end else begin
          valid = 1'b0;
        end
      end
      checkOutput("t5_product_hold", 32'(holdOk), 32'd1);
    end

    // Reset in the third WORK cycle aborts the operation.
    begin
      bit sawReady;
      @(negedge clk);
      multiplicand = 8'd100;
      multiplier   = 8'd3;
      sgn          = 1'b0;
      valid        = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6_abort_busy", 32'(busy), 32'd0);
      checkOutput("t6_abort_product", 32'(product), 32'd0);
      rst      = 1'b1;
      sawReady = 1'b0;
      repeat (N + 3) begin
        @(negedge clk);
        if (ready) sawReady = 1'b1;
      end
      checkOutput("t6_no_ready", 32'(sawReady), 32'd0);
      applyStimulus(8'd7, 8'd9, 1'b0, lat, busyOk);
      checkOutput("t6_after_reset", 32'(product), 32'h003F);
    end

    for (int i = 0; i < 60; i++) begin
      ra = WID'($urandom);
      rb = WID'($urandom);
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ra = '0;
      if ($urandom_range(0, 9) == 0) rb = '0;
      applyStimulus(ra, rb, rs, lat, busyOk);
      checkOutput($sformatf("rand_lat_%0d", i), 32'(lat), 32'(refLatency(ra, rb)));
      checkOutput($sformatf("rand_prod_%0d", i), 32'(product), 32'(refProduct(ra, rb, rs)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
